// File: rtl/data_mem_bank.sv
// data_mem_bank: single-port data memory bank for the load/store stage.
// It has per-byte write enables and a valid/ready request port with no
// response backpressure. Read latency is 1 or 2 cycles. Out-of-range
// addresses are flagged in the response. The array is swept to zero
// after reset, and again whenever clr is pulsed.

module data_mem_bank #(
    parameter int DEPTH    = 128,
    parameter int WIDTH    = 32,
    parameter int ADR_BITS = 32,
    parameter int READ_LAT = 1,
    parameter int BYTES    = WIDTH / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                wen,
    input  logic [BYTES-1:0]    be,
    input  logic [ADR_BITS-1:0] adr,
    input  logic [WIDTH-1:0]    din,
    output logic                rsp_valid,
    output logic                rsp_wr,
    output logic                rsp_err,
    output logic [WIDTH-1:0]    dout,
    output logic                busy
);

    localparam int IDX_BITS = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_BITS-1:0] sweep_cnt;
    logic                ready_q;
    logic                busy_q;

    logic [WIDTH-1:0]    mem [DEPTH];

    logic                accept;
    logic                in_range;
    logic [IDX_BITS-1:0] idx;
    logic [WIDTH-1:0]    rd_word;

    // Response pipeline; entry READ_LAT-1 drives the outputs.
    logic [READ_LAT-1:0] p_valid;
    logic [READ_LAT-1:0] p_wr;
    logic [READ_LAT-1:0] p_err;
    logic [WIDTH-1:0]    p_data [READ_LAT];

    assign accept   = req_valid && ready_q;
    assign in_range = (adr < ADR_BITS'(DEPTH));
    assign idx      = adr[IDX_BITS-1:0];
    // Out-of-range reads return zero and never touch the array.
    assign rd_word  = in_range ? mem[idx] : '0;

    // Control FSM: the sweep counter walks 0..DEPTH-1, then the bank opens for requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (sweep_cnt == IDX_BITS'(DEPTH - 1)) begin
                        state     <= RUN;
                        sweep_cnt <= '0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + IDX_BITS'(1);
                    end
                end
                RUN: begin
                    if (clr) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    sweep_cnt <= '0;
                    ready_q   <= 1'b0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Array writes: the zero sweep while clearing, otherwise byte-masked in-range writes.
    // NOTE: the array has no reset branch on purpose; the sweep is what clears it, and a
    // reset on the storage would turn it into thousands of flops instead of a RAM.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else if (accept && wen && in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline. The data field only advances behind a read, so dout holds the
    // last read value across write responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= '0;
            p_wr    <= '0;
            p_err   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                p_data[i] <= '0;
            end
        end else begin
            p_valid[0] <= accept;
            p_wr[0]    <= accept && wen;
            p_err[0]   <= accept && !in_range;
            if (accept && !wen) begin
                p_data[0] <= rd_word;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_wr[i]    <= p_wr[i-1];
                p_err[i]   <= p_err[i-1];
                if (p_valid[i-1] && !p_wr[i-1]) begin
                    p_data[i] <= p_data[i-1];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = p_valid[READ_LAT-1];
    assign rsp_wr    = p_wr[READ_LAT-1];
    assign rsp_err   = p_err[READ_LAT-1];
    assign dout      = p_data[READ_LAT-1];

endmodule
